// File: rtl/dunc16_sequencer_if.sv
// Bus bundle between the DUNC16 control sequencer (master) and its datapath (slave):
// opcode and memory handshake in, datapath strobes/selects and the write latch out.
interface dunc16_sequencer_if;
  logic [3:0] IR_OP;
  logic       MEM_ACK;
  logic       LD_MA, MA_SEL, MEM_RD, LD_MD, MD_SEL;
  logic       LD_IR, INC_PC, LD_PC, LD_AC, AC_SEL;
  logic       SETWRITE, CLRWRITE, WRITE;

  modport master (
    input  IR_OP, MEM_ACK,
    output LD_MA, MA_SEL, MEM_RD, LD_MD, MD_SEL,
           LD_IR, INC_PC, LD_PC, LD_AC, AC_SEL,
           SETWRITE, CLRWRITE, WRITE
  );

  modport slave (
    output IR_OP, MEM_ACK,
    input  LD_MA, MA_SEL, MEM_RD, LD_MD, MD_SEL,
           LD_IR, INC_PC, LD_PC, LD_AC, AC_SEL,
           SETWRITE, CLRWRITE, WRITE
  );
endinterface

// File: rtl/dunc16_sequencer.sv
// DUNC16 four-phase fetch/execute control sequencer with halt/resume and write latch.
// Optional memory wait states and bus-error timeout: define DUNC16_WAITSTATE_EN.
module dunc16_sequencer #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RUN,
  dunc16_sequencer_if.master  bus,
  output logic                T0,
  output logic                T1,
  output logic                T2,
  output logic                T3,
  output logic                FETCH,
  output logic                EXECUTE,
  output logic                HALTED,
  output logic                ILLEGAL,
  output logic                BUS_ERR
);

  localparam logic [1:0] PH_T0 = 2'd0;
  localparam logic [1:0] PH_T1 = 2'd1;
  localparam logic [1:0] PH_T2 = 2'd2;
  localparam logic [1:0] PH_T3 = 2'd3;

  localparam logic MC_FETCH = 1'b0;
  localparam logic MC_EXEC  = 1'b1;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [1:0] r_phase;
  logic       r_major;
  logic       r_halted;
  logic       r_write;

  logic w_lda, w_sta, w_add, w_jmp, w_hlt, w_legal;
  logic w_mem_phase;
  logic w_stall;
  logic w_timeout;

  assign w_lda   = (bus.IR_OP == OP_LDA);
  assign w_sta   = (bus.IR_OP == OP_STA);
  assign w_add   = (bus.IR_OP == OP_ADD);
  assign w_jmp   = (bus.IR_OP == OP_JMP);
  assign w_hlt   = (bus.IR_OP == OP_HLT);
  assign w_legal = (bus.IR_OP == OP_NOP) | w_lda | w_sta | w_add | w_jmp | w_hlt;

  assign T0      = (r_phase == PH_T0);
  assign T1      = (r_phase == PH_T1);
  assign T2      = (r_phase == PH_T2);
  assign T3      = (r_phase == PH_T3);
  assign FETCH   = (r_major == MC_FETCH);
  assign EXECUTE = (r_major == MC_EXEC);
  assign HALTED  = r_halted;
  assign bus.WRITE = r_write;

  // Strobes are silent while halted and while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bus.LD_MA    = 1'b0;
    bus.MA_SEL   = 1'b0;
    bus.MEM_RD   = 1'b0;
    bus.LD_MD    = 1'b0;
    bus.MD_SEL   = 1'b0;
    bus.LD_IR    = 1'b0;
    bus.INC_PC   = 1'b0;
    bus.LD_PC    = 1'b0;
    bus.LD_AC    = 1'b0;
    bus.AC_SEL   = 1'b0;
    bus.SETWRITE = 1'b0;
    bus.CLRWRITE = 1'b0;
    ILLEGAL      = 1'b0;
    if (RESET && !r_halted) begin
      if (r_major == MC_FETCH) begin
        case (r_phase)
          PH_T0:   bus.LD_MA = 1'b1;
          PH_T1:   begin bus.MEM_RD = 1'b1; bus.LD_MD = 1'b1; end
          PH_T2:   begin bus.LD_IR = 1'b1; bus.INC_PC = 1'b1; end
          default: ;
        endcase
      end else begin
        case (r_phase)
          PH_T0: begin
            bus.LD_MA  = w_lda | w_sta | w_add;
            bus.MA_SEL = w_lda | w_sta | w_add;
            bus.LD_PC  = w_jmp;
            ILLEGAL    = ~w_legal;
          end
          PH_T1: begin
            bus.MEM_RD = w_lda | w_add;
            bus.LD_MD  = w_lda | w_add | w_sta;
            bus.MD_SEL = w_sta;
          end
          PH_T2: begin
            bus.LD_AC    = w_lda | w_add;
            bus.AC_SEL   = w_add;
            bus.SETWRITE = w_sta;
          end
          default: bus.CLRWRITE = w_sta;
        endcase
      end
    end
  end

  // Phases that wait on the memory handshake: reads in T1 and the STA write in T2.
  assign w_mem_phase = bus.MEM_RD | bus.SETWRITE;

`ifdef DUNC16_WAITSTATE_EN
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_bus_err;

  assign w_stall   = w_mem_phase & ~bus.MEM_ACK;
  assign w_timeout = w_stall & (r_wait_cnt == CW'(MEM_TIMEOUT - 1));
  assign BUS_ERR   = r_bus_err;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else if (r_halted) begin
      if (RUN) r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b1;
    end else if (w_stall) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  logic w_unused;

  assign w_stall   = 1'b0;
  assign w_timeout = 1'b0;
  assign BUS_ERR   = 1'b0;
  assign w_unused  = &{1'b0, bus.MEM_ACK, w_mem_phase, MEM_TIMEOUT[0]};
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      r_phase  <= PH_T0;
      r_major  <= MC_FETCH;
      r_halted <= 1'b0;
      r_write  <= 1'b0;
    end else if (r_halted) begin
      // Resume skips the suppressed T0 and continues the fetch at T1.
      if (RUN) begin
        r_halted <= 1'b0;
        r_phase  <= PH_T1;
      end
    end else if (w_timeout) begin
      r_halted <= 1'b1;
      r_write  <= 1'b0;
      r_phase  <= PH_T0;
      r_major  <= MC_FETCH;
    end else begin
      if (bus.SETWRITE) r_write <= 1'b1;
      if (bus.CLRWRITE) r_write <= 1'b0;
      if (!w_stall) begin
        r_phase <= r_phase + 2'd1;
        if (r_phase == PH_T3) begin
          r_major <= (r_major == MC_FETCH) ? MC_EXEC : MC_FETCH;
          if (r_major == MC_EXEC && w_hlt) r_halted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dunc16_sequencer.sv
// Directed self-checking bench for dunc16_sequencer: instruction flows, halt/resume,
// illegal opcode, reset mid-write, and (with DUNC16_WAITSTATE_EN) stalls and bus error.
module tb_dunc16_sequencer;

  localparam logic [11:0] S_LD_MA    = 12'h800;
  localparam logic [11:0] S_MA_SEL   = 12'h400;
  localparam logic [11:0] S_MEM_RD   = 12'h200;
  localparam logic [11:0] S_LD_MD    = 12'h100;
  localparam logic [11:0] S_MD_SEL   = 12'h080;
  localparam logic [11:0] S_LD_IR    = 12'h040;
  localparam logic [11:0] S_INC_PC   = 12'h020;
  localparam logic [11:0] S_LD_PC    = 12'h010;
  localparam logic [11:0] S_LD_AC    = 12'h008;
  localparam logic [11:0] S_AC_SEL   = 12'h004;
  localparam logic [11:0] S_SETWRITE = 12'h002;
  localparam logic [11:0] S_CLRWRITE = 12'h001;

  logic CLK, RESET, RUN;
  logic T0, T1, T2, T3, FETCH, EXECUTE, HALTED, ILLEGAL, BUS_ERR;
  int   n_assert = 0;
  int   n_fail   = 0;

  dunc16_sequencer_if bus ();

  dunc16_sequencer #(.MEM_TIMEOUT(8)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .bus(bus),
    .T0(T0), .T1(T1), .T2(T2), .T3(T3), .FETCH(FETCH), .EXECUTE(EXECUTE),
    .HALTED(HALTED), .ILLEGAL(ILLEGAL), .BUS_ERR(BUS_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] obs_state();
    return {T0, T1, T2, T3, FETCH, EXECUTE, HALTED, ILLEGAL, BUS_ERR, bus.WRITE};
  endfunction

  function automatic logic [11:0] obs_strobe();
    return {bus.LD_MA, bus.MA_SEL, bus.MEM_RD, bus.LD_MD, bus.MD_SEL, bus.LD_IR,
            bus.INC_PC, bus.LD_PC, bus.LD_AC, bus.AC_SEL, bus.SETWRITE, bus.CLRWRITE};
  endfunction

  function automatic logic [9:0] exp_state(input int ph, input logic ex, input logic h,
                                           input logic il, input logic be, input logic wr);
    logic [3:0] t;
    t = 4'b1000 >> ph;
    return {t, ~ex, ex, h, il, be, wr};
  endfunction

  function automatic logic [11:0] exp_exec(input logic [3:0] op, input int ph);
    case (op)
      4'h1: case (ph) 0: return S_LD_MA | S_MA_SEL; 1: return S_MEM_RD | S_LD_MD;
                      2: return S_LD_AC; default: return 12'h0; endcase
      4'h2: case (ph) 0: return S_LD_MA | S_MA_SEL; 1: return S_LD_MD | S_MD_SEL;
                      2: return S_SETWRITE; default: return S_CLRWRITE; endcase
      4'h3: case (ph) 0: return S_LD_MA | S_MA_SEL; 1: return S_MEM_RD | S_LD_MD;
                      2: return S_LD_AC | S_AC_SEL; default: return 12'h0; endcase
      4'h4: return (ph == 0) ? S_LD_PC : 12'h0;
      default: return 12'h0;
    endcase
  endfunction

  function automatic logic [11:0] exp_fetch(input int ph);
    case (ph)
      0: return S_LD_MA;
      1: return S_MEM_RD | S_LD_MD;
      2: return S_LD_IR | S_INC_PC;
      default: return 12'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check state and strobes in the current cycle, then move to the next falling edge.
  task automatic step(input string tag, input int ph, input logic ex, input logic h,
                      input logic il, input logic be, input logic wr, input logic [11:0] s);
    check({tag, "_state"}, 32'(obs_state()), 32'(exp_state(ph, ex, h, il, be, wr)));
    check({tag, "_strobe"}, 32'(obs_strobe()), 32'(s));
    @(negedge CLK);
  endtask

  task automatic run_fetch(input string tag);
    for (int ph = 0; ph < 4; ph++)
      step($sformatf("%s_F%0d", tag, ph), ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(ph));
  endtask

  task automatic run_exec(input logic [3:0] op);
    logic il;
    il = !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF});
    for (int ph = 0; ph < 4; ph++)
      step($sformatf("op%0h_E%0d", op, ph), ph, 1'b1, 1'b0, il && (ph == 0), 1'b0,
           (op == 4'h2) && (ph == 3), exp_exec(op, ph));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(obs_state()), 32'(exp_state(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
    check({tag, "_strobe"}, 32'(obs_strobe()), 32'h0);
  endtask

  initial begin
    RESET = 1'b0;
    RUN = 1'b0;
    bus.IR_OP = 4'h1;
    bus.MEM_ACK = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset("reset_hold");

    RESET = 1'b1;
    #1;
    run_fetch("lda");
    run_exec(4'h1);

    bus.IR_OP = 4'h2;
    run_fetch("sta");
    run_exec(4'h2);

    bus.IR_OP = 4'h3;
    step("add_F0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(0));
    RUN = 1'b1;
    step("run_ignored_F1", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(1));
    RUN = 1'b0;
    step("add_F2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(2));
    step("add_F3", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(3));
    run_exec(4'h3);

    bus.IR_OP = 4'h4;
    run_fetch("jmp");
    run_exec(4'h4);

    bus.IR_OP = 4'h7;
    run_fetch("ill");
    run_exec(4'h7);

    bus.IR_OP = 4'hF;
    run_fetch("hlt");
    run_exec(4'hF);
    for (int i = 0; i < 20; i++)
      step($sformatf("halted_%0d", i), 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0);
    bus.IR_OP = 4'h0;
    RUN = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
    step("resume_F1", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(1));
    step("resume_F2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(2));
    step("resume_F3", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(3));
    run_exec(4'h0);

`ifdef DUNC16_WAITSTATE_EN
    bus.MEM_ACK = 1'b0;
    step("ws_F0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(0));
    for (int i = 0; i < 3; i++)
      step($sformatf("ws_stall_%0d", i), 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(1));
    bus.MEM_ACK = 1'b1;
    step("ws_F1_ack", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(1));
    step("ws_F2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(2));
    step("ws_F3", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(3));
    run_exec(4'h0);

    bus.MEM_ACK = 1'b0;
    step("to_F0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(0));
    for (int i = 0; i < 8; i++)
      step($sformatf("to_stall_%0d", i), 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(1));
    step("bus_err_halt", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0);
    bus.MEM_ACK = 1'b1;
    RUN = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
    step("berr_resume_F1", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(1));
    step("berr_resume_F2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(2));
    step("berr_resume_F3", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(3));
    run_exec(4'h0);

    bus.IR_OP = 4'h2;
    run_fetch("wsta");
    step("wsta_E0", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_exec(4'h2, 0));
    step("wsta_E1", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_exec(4'h2, 1));
    bus.MEM_ACK = 1'b0;
    step("wsta_E2a", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_SETWRITE);
    check("wsta_E2b_state", 32'(obs_state()), 32'(exp_state(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)));
    RESET = 1'b0;
    #1;
    check_reset("reset_in_E2");
    @(negedge CLK);
    bus.MEM_ACK = 1'b1;
    RESET = 1'b1;
    #1;
    step("post_rst1_F0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(0));
    step("post_rst1_F1", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(1));
    @(negedge CLK);
    @(negedge CLK);
`else
    bus.MEM_ACK = 1'b0;
    bus.IR_OP = 4'h1;
    run_fetch("noack");
    run_exec(4'h1);
    bus.MEM_ACK = 1'b1;
`endif

    bus.IR_OP = 4'h2;
    run_fetch("rsta");
    for (int ph = 0; ph < 3; ph++)
      step($sformatf("rsta_E%0d", ph), ph, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_exec(4'h2, ph));
    check("rsta_E3_state", 32'(obs_state()), 32'(exp_state(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)));
    RESET = 1'b0;
    #1;
    check_reset("reset_mid_write");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    step("post_rst_F0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(0));
    step("post_rst_F1", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fetch(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
